// File: rtl/instrfetch_pkg.sv
// Shared fetch-path widths, types and the line-alignment helper.
package instrfetch_pkg;
   localparam int XLEN      = 32;
   localparam int BUS_WID   = 64;
   localparam int BUS_BYTES = BUS_WID / 8;
   localparam int OFF_W     = $clog2(BUS_BYTES);

   typedef logic [XLEN-1:0]    addr_t;
   typedef logic [BUS_WID-1:0] line_t;

   function automatic addr_t line_align(input addr_t a);
      return {a[XLEN-1:OFF_W], {OFF_W{1'b0}}};
   endfunction
endpackage

// File: rtl/fetch_credit.sv
// In-flight request counter plus the count of in-flight responses that belong
// to an abandoned path.
module fetch_credit #(
   parameter int MAX_OUT = 2,
   localparam int CW = $clog2(MAX_OUT + 1)
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_issue,
   input  logic i_rvld,
   input  logic i_flush,
   output logic o_credit,
   output logic o_rsp,
   output logic o_stale
);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

   logic [CW-1:0] r_out, r_disc;
   logic [CW-1:0] w_out_nxt, w_disc_nxt;

   assign o_rsp    = i_rvld && (r_out != '0);
   assign o_credit = r_out < MAX_C;
   assign o_stale  = r_disc != '0;

   always_comb begin
      w_out_nxt  = r_out;
      w_disc_nxt = r_disc;
      if (i_issue && r_out != MAX_C) w_out_nxt = w_out_nxt + CW'(1);
      if (o_rsp)                     w_out_nxt = w_out_nxt - CW'(1);
      // A flush makes every request still in flight stale, so the discard
      // count is the old stale count plus the live ones, less any response
      // retiring this same cycle.
      if (i_flush)                   w_disc_nxt = r_out - CW'(o_rsp);
      else if (o_rsp && o_stale)     w_disc_nxt = r_disc - CW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_out  <= '0;
         r_disc <= '0;
      end else begin
         r_out  <= w_out_nxt;
         r_disc <= w_disc_nxt;
      end
   end
endmodule

// File: rtl/instrfetch.sv
// Fetch controller: owns the fetch PC, issues line requests, forwards
// current-path lines and converts redirects into buffer restarts.
module instrfetch
   import instrfetch_pkg::*;
#(
   parameter int    MAX_OUT  = 2,
   parameter addr_t RESET_PC = '0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_redirect_vld,
   input  logic [XLEN-1:0]    i_redirect_pc,
   input  logic               i_buffer_free,
   output logic               o_imem_req,
   output logic [XLEN-1:0]    o_imem_addr,
   input  logic               i_imem_ack,
   input  logic               i_imem_rvld,
   input  logic [BUS_WID-1:0] i_imem_rdata,
   output logic               o_jump_vld,
   output logic [XLEN-1:0]    o_jump_pc,
   output logic               o_line_vld,
   output logic [BUS_WID-1:0] o_line_data
);
   logic  r_boot;
   addr_t r_fetch_addr;
   logic  w_flush, w_issue, w_credit, w_rsp, w_stale;
   addr_t w_target;

   // Boot behaves as a redirect to RESET_PC; an external redirect wins.
   assign w_flush     = r_boot || i_redirect_vld;
   assign w_target    = (i_redirect_vld ? i_redirect_pc : RESET_PC) & ~addr_t'(1);
   assign o_imem_req  = !r_boot && !i_redirect_vld && i_buffer_free && w_credit;
   assign o_imem_addr = r_fetch_addr;
   assign w_issue     = o_imem_req && i_imem_ack;

   fetch_credit #(.MAX_OUT(MAX_OUT)) u_credit (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_issue (w_issue),
      .i_rvld  (i_imem_rvld),
      .i_flush (w_flush),
      .o_credit(w_credit),
      .o_rsp   (w_rsp),
      .o_stale (w_stale)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_boot       <= 1'b1;
         r_fetch_addr <= line_align(RESET_PC);
         o_jump_vld   <= 1'b0;
         o_jump_pc    <= '0;
         o_line_vld   <= 1'b0;
         o_line_data  <= '0;
      end else begin
         r_boot     <= 1'b0;
         o_jump_vld <= w_flush;
         o_line_vld <= 1'b0;
         if (w_flush) begin
            o_jump_pc    <= w_target;
            r_fetch_addr <= line_align(w_target);
         end else begin
            if (w_issue) r_fetch_addr <= r_fetch_addr + addr_t'(BUS_BYTES);
            if (w_rsp && !w_stale) begin
               o_line_vld  <= 1'b1;
               o_line_data <= i_imem_rdata;
            end
         end
      end
   end
endmodule

// File: tb/tb_instrfetch.sv
// Fetch controller bench: randomized bus/back-pressure/redirect traffic against
// a path-epoch reference model, plus directed corner steps.
module tb_instrfetch;
   import instrfetch_pkg::*;

   localparam int          MAX_OUT = 2;
   localparam logic [31:0] RPC     = 32'h0000_0080;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_vld;
   logic [31:0] redirect_pc;
   logic        buffer_free;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        imem_rvld;
   logic [63:0] imem_rdata;
   logic        jump_vld;
   logic [31:0] jump_pc;
   logic        line_vld;
   logic [63:0] line_data;

   always #5 clk = ~clk;

   instrfetch #(.MAX_OUT(MAX_OUT), .RESET_PC(RPC)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_redirect_vld(redirect_vld), .i_redirect_pc(redirect_pc),
      .i_buffer_free(buffer_free),
      .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack),
      .i_imem_rvld(imem_rvld), .i_imem_rdata(imem_rdata),
      .o_jump_vld(jump_vld), .o_jump_pc(jump_pc),
      .o_line_vld(line_vld), .o_line_data(line_data)
   );

   // Every accepted request, tagged with the path it was issued on.
   typedef struct {
      logic [31:0] addr;
      int          ep;
      int          ready;
   } pend_t;
   pend_t q[$];

   int          total = 0, bad = 0, cyc = 0, m_ep = 0, run = 0;
   bit          m_boot;
   logic [31:0] m_next;
   bit          e_req, e_jump, e_line;
   logic [31:0] e_jpc;
   logic [63:0] e_data;
   int          g_ack = 0, g_rsp = 0;  // ack: 0 always,1 random,2 after 3 cycles
   bit          g_bf = 1'b0, g_bad_rvld = 1'b0;

   function automatic logic [63:0] mem(input logic [31:0] a);
      return {a ^ 32'hA5A5_5A5A, ~a};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit redir, input logic [31:0] rpc);
      bit    can, flush;
      pend_t e, n;
      redirect_vld = redir;
      redirect_pc  = rpc;
      buffer_free  = g_bf;
      case (g_ack)
         0:       imem_ack = 1'b1;
         1:       imem_ack = ($urandom_range(0, 3) != 0);
         default: imem_ack = (run >= 2);
      endcase
      can        = (q.size() > 0) && (q[0].ready <= cyc);
      imem_rvld  = g_bad_rvld || (can && (g_rsp == 1 || (g_rsp == 2 && $urandom_range(0, 1) == 1)));
      imem_rdata = can ? mem(q[0].addr) : {$urandom, $urandom};
      #1;
      e_req = !m_boot && !redir && g_bf && (q.size() < MAX_OUT);
      chk("imem_req", imem_req, e_req);
      if (e_req) chk("imem_addr", imem_addr, m_next);
      @(posedge clk);
      flush  = redir || m_boot;
      e_line = 1'b0;
      if (imem_rvld && q.size() > 0) begin
         e = q.pop_front();
         if (!flush && e.ep == m_ep) begin
            e_line = 1'b1;
            e_data = mem(e.addr);
         end
      end
      if (e_req && imem_ack) begin
         n.addr = m_next; n.ep = m_ep; n.ready = cyc + $urandom_range(1, 4);
         q.push_back(n);
         m_next = m_next + 32'd8;
      end
      e_jump = flush;
      if (flush) begin
         e_jpc  = redir ? {rpc[31:1], 1'b0} : RPC;
         m_ep++;
         m_next = {e_jpc[31:3], 3'b000};
      end
      m_boot = 1'b0;
      if (e_req && !imem_ack) run++; else run = 0;
      cyc++;
      @(negedge clk);
      chk("jump_vld", jump_vld, e_jump);
      if (e_jump) chk("jump_pc", jump_pc, e_jpc);
      chk("line_vld", line_vld, e_line);
      if (e_line) chk("line_data", line_data, e_data);
   endtask

   task automatic drain();
      g_bf  = 1'b0;
      g_rsp = 1;
      for (int i = 0; i < 40 && q.size() > 0; i++) step(1'b0, 32'h0);
   endtask

   initial begin
      rst = 1'b1; redirect_vld = 1'b0; redirect_pc = '0; buffer_free = 1'b0;
      imem_ack = 1'b0; imem_rvld = 1'b0; imem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_jump_vld", jump_vld, 1'b0);
      chk("rst_jump_pc", jump_pc, 32'h0);
      chk("rst_line_vld", line_vld, 1'b0);
      chk("rst_line_data", line_data, 64'h0);
      chk("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, RPC);
      rst = 1'b0; m_boot = 1'b1; m_next = RPC;

      // boot pulse, then consecutive line requests
      g_bf = 1'b1; g_ack = 0; g_rsp = 0;
      step(1'b0, 32'h0);
      chk("boot_jpc", jump_pc, 32'h80);
      chk("first_addr", imem_addr, 32'h80);
      step(1'b0, 32'h0);
      chk("second_addr", imem_addr, 32'h88);
      step(1'b0, 32'h0);
      chk("credit_stall", imem_req, 1'b0);
      g_rsp = 1;
      repeat (8) step(1'b0, 32'h0);

      // random traffic
      g_ack = 1; g_rsp = 2;
      for (int i = 0; i < 400; i++) begin
         g_bf = ($urandom_range(0, 3) != 0);
         step($urandom_range(0, 15) == 0, $urandom);
      end

      // back-pressure, then a slow-ack bus
      g_bf = 1'b0;
      repeat (10) step(1'b0, 32'h0);
      g_bf = 1'b1; g_ack = 2;
      repeat (100) step(1'b0, 32'h0);
      drain();

      // two stale requests dropped across a redirect
      g_bf = 1'b1; g_ack = 0; g_rsp = 0;
      step(1'b0, 32'h0);
      step(1'b0, 32'h0);
      step(1'b1, 32'h1006);
      chk("redir_jpc", jump_pc, 32'h1006);
      redirect_vld = 1'b0; #1;
      chk("redir_addr", imem_addr, 32'h1000);
      g_rsp = 1;
      repeat (10) step(1'b0, 32'h0);
      drain();

      // response in the redirect cycle
      g_bf = 1'b1; g_ack = 0; g_rsp = 0;
      step(1'b0, 32'h0);
      g_bf = 1'b0;
      for (int i = 0; i < 6 && q.size() > 0 && q[0].ready > cyc; i++) step(1'b0, 32'h0);
      g_rsp = 1;
      step(1'b1, 32'h400);
      chk("same_cyc_line", line_vld, 1'b0);
      g_bf = 1'b1;
      repeat (8) step(1'b0, 32'h0);
      drain();

      // back-to-back redirects
      g_bf = 1'b1; g_rsp = 0;
      step(1'b0, 32'h0);
      step(1'b0, 32'h0);
      step(1'b1, 32'h200);
      step(1'b1, 32'h300);
      chk("b2b_jpc", jump_pc, 32'h300);
      g_rsp = 2;
      repeat (20) step(1'b0, 32'h0);
      drain();

      // address wrap
      g_bf = 1'b1; g_ack = 0; g_rsp = 1;
      step(1'b1, 32'hFFFF_FFF8);
      redirect_vld = 1'b0; #1;
      chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
      step(1'b0, 32'h0);
      chk("wrap_addr1", imem_addr, 32'h0000_0000);
      repeat (6) step(1'b0, 32'h0);
      drain();

      // spurious response with nothing in flight must not underflow credit
      g_bad_rvld = 1'b1;
      step(1'b0, 32'h0);
      g_bad_rvld = 1'b0;
      g_bf = 1'b1; g_rsp = 0;
      repeat (4) step(1'b0, 32'h0);
      g_rsp = 1;
      repeat (8) step(1'b0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
